// File: rtl/spi_dev_cfg_seq.sv
// spi_dev_cfg_seq: table-driven SPI device bring-up (ID check, table writes, final status poll).
// Per-entry read-back verification is compiled in when SPI_CFG_VERIFY_EN is defined.
module spi_dev_cfg_seq #(
    parameter int               CMD_W       = 24,
    parameter int               RD_W        = 8,
    parameter int               ADDR_W      = 7,
    parameter int               NUM_ENTRIES = 64,
    parameter logic [CMD_W-1:0] ID_CMD      = 24'h008003,
    parameter logic [RD_W-1:0]  ID_VAL      = 8'h53,
    parameter logic [CMD_W-1:0] FIN_CMD     = 24'h00801C,
    parameter logic [RD_W-1:0]  FIN_VAL     = 8'h01,
    parameter logic [RD_W-1:0]  FIN_MASK    = 8'hFF,
    parameter int               TIMEOUT_CYC = 65535,
    parameter int               MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cfg_start,
    output logic              o_spi_wr_cmd,
    output logic              o_spi_rd_cmd,
    output logic [CMD_W-1:0]  o_spi_wr_data,
    input  logic [RD_W-1:0]   i_spi_rd_data,
    input  logic              i_spi_busy,
    input  logic              i_spi_done,
    output logic [ADDR_W-1:0] o_tbl_addr,
    input  logic [CMD_W-1:0]  i_tbl_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [2:0]        o_err_code,
    output logic [ADDR_W-1:0] o_err_addr,
    output logic [3:0]        o_dbg_state
);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_ID_RD = 4'd1, S_ID_WAIT = 4'd2, S_FETCH = 4'd3,
        S_ENTRY_WR = 4'd4, S_WR_WAIT = 4'd5, S_VFY_RD = 4'd6, S_VFY_WAIT = 4'd7,
        S_FIN_RD = 4'd8, S_FIN_WAIT = 4'd9, S_DONE = 4'd10, S_ERR = 4'd11
    } state_t;

    state_t             state, state_n;
    logic               start_q, start_edge, accept;
    logic [ADDR_W:0]    idx, idx_n, idx_inc;
    logic [CMD_W-2:0]   entry;
    logic [RTY_W-1:0]   retry;
    logic [TMR_W-1:0]   timer;
    logic               fetch_ph, ph_n;
    logic               wr_pulse, rd_pulse, timer_clr, in_wait, timed_out;
    logic               retry_clr, retry_inc, entry_ld, done_set, err_set, adv_last;
    logic [CMD_W-1:0]   cmd_word;
    logic [2:0]         err_code_n;
    logic [ADDR_W-1:0]  err_addr_n;

    assign o_dbg_state = state;
    assign start_edge  = i_cfg_start & ~start_q;
    assign idx_inc     = idx + 1'b1;
    assign adv_last    = (idx_inc == (ADDR_W+1)'(NUM_ENTRIES));
    assign timed_out   = (timer == TMR_W'(TIMEOUT_CYC));
    assign in_wait     = (state == S_ID_WAIT) || (state == S_WR_WAIT) ||
                         (state == S_VFY_WAIT) || (state == S_FIN_WAIT);

    // Handshake with the SPI master: a command is issued (one-cycle wr/rd pulse with its word)
    // only in a cycle where i_spi_busy is low; the transaction completes on the i_spi_done pulse,
    // which also qualifies i_spi_rd_data. A done arriving with the timeout wins.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        ph_n       = 1'b0;
        accept     = 1'b0;
        wr_pulse   = 1'b0;
        rd_pulse   = 1'b0;
        cmd_word   = '0;
        timer_clr  = 1'b0;
        retry_clr  = 1'b0;
        retry_inc  = 1'b0;
        entry_ld   = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        err_code_n = 3'd0;
        err_addr_n = '0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_edge) begin
                    accept  = 1'b1;
                    idx_n   = '0;
                    state_n = S_ID_RD;
                end
            end
            S_ID_RD: begin
                if (!i_spi_busy) begin
                    rd_pulse  = 1'b1;
                    cmd_word  = ID_CMD;
                    timer_clr = 1'b1;
                    state_n   = S_ID_WAIT;
                end
            end
            S_ID_WAIT: begin
                if (i_spi_done) begin
                    retry_clr = 1'b1;
                    if (i_spi_rd_data == ID_VAL) begin
                        idx_n   = '0;
                        state_n = S_FETCH;
                    end else begin
                        err_set    = 1'b1;
                        err_code_n = 3'd1;
                        state_n    = S_ERR;
                    end
                end else if (timed_out) begin
                    err_set    = 1'b1;
                    err_code_n = 3'd2;
                    state_n    = S_ERR;
                end
            end
            S_FETCH: begin
                // Phase 0 presents the address; phase 1 captures the ROM word.
                retry_clr = 1'b1;
                if (!fetch_ph) begin
                    ph_n = 1'b1;
                end else begin
                    entry_ld = 1'b1;
                    state_n  = (&i_tbl_data) ? S_FIN_RD : S_ENTRY_WR;
                end
            end
            S_ENTRY_WR: begin
                if (!i_spi_busy) begin
                    wr_pulse  = 1'b1;
                    cmd_word  = {1'b0, entry};
                    timer_clr = 1'b1;
                    state_n   = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (i_spi_done) begin
`ifdef SPI_CFG_VERIFY_EN
                    state_n = S_VFY_RD;
`else
                    idx_n     = idx_inc;
                    retry_clr = 1'b1;
                    state_n   = adv_last ? S_FIN_RD : S_FETCH;
`endif
                end else if (timed_out) begin
                    err_set    = 1'b1;
                    err_code_n = 3'd2;
                    err_addr_n = idx[ADDR_W-1:0];
                    state_n    = S_ERR;
                end
            end
`ifdef SPI_CFG_VERIFY_EN
            S_VFY_RD: begin
                if (!i_spi_busy) begin
                    rd_pulse  = 1'b1;
                    cmd_word  = {1'b1, entry[CMD_W-2:RD_W], {RD_W{1'b0}}};
                    timer_clr = 1'b1;
                    state_n   = S_VFY_WAIT;
                end
            end
            S_VFY_WAIT: begin
                if (i_spi_done) begin
                    if (i_spi_rd_data == entry[RD_W-1:0]) begin
                        idx_n     = idx_inc;
                        retry_clr = 1'b1;
                        state_n   = adv_last ? S_FIN_RD : S_FETCH;
                    end else if (retry == RTY_W'(MAX_RETRY)) begin
                        err_set    = 1'b1;
                        err_code_n = 3'd3;
                        err_addr_n = idx[ADDR_W-1:0];
                        state_n    = S_ERR;
                    end else begin
                        retry_inc = 1'b1;
                        state_n   = S_ENTRY_WR;
                    end
                end else if (timed_out) begin
                    err_set    = 1'b1;
                    err_code_n = 3'd2;
                    err_addr_n = idx[ADDR_W-1:0];
                    state_n    = S_ERR;
                end
            end
`endif
            S_FIN_RD: begin
                if (!i_spi_busy) begin
                    rd_pulse  = 1'b1;
                    cmd_word  = FIN_CMD;
                    timer_clr = 1'b1;
                    state_n   = S_FIN_WAIT;
                end
            end
            S_FIN_WAIT: begin
                if (i_spi_done) begin
                    if ((i_spi_rd_data & FIN_MASK) == (FIN_VAL & FIN_MASK)) begin
                        done_set = 1'b1;
                        state_n  = S_DONE;
                    end else if (retry == RTY_W'(MAX_RETRY)) begin
                        err_set    = 1'b1;
                        err_code_n = 3'd4;
                        state_n    = S_ERR;
                    end else begin
                        retry_inc = 1'b1;
                        state_n   = S_FIN_RD;
                    end
                end else if (timed_out) begin
                    err_set    = 1'b1;
                    err_code_n = 3'd2;
                    state_n    = S_ERR;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            start_q       <= 1'b0;
            idx           <= '0;
            entry         <= '0;
            retry         <= '0;
            timer         <= '0;
            fetch_ph      <= 1'b0;
            o_spi_wr_cmd  <= 1'b0;
            o_spi_rd_cmd  <= 1'b0;
            o_spi_wr_data <= '0;
            o_tbl_addr    <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            o_err_code    <= 3'd0;
            o_err_addr    <= '0;
        end else begin
            state         <= state_n;
            start_q       <= i_cfg_start;
            idx           <= idx_n;
            fetch_ph      <= ph_n;
            o_spi_wr_cmd  <= wr_pulse;
            o_spi_rd_cmd  <= rd_pulse;
            o_spi_wr_data <= cmd_word;
            o_tbl_addr    <= idx_n[ADDR_W-1:0];
            o_busy        <= !(state_n == S_IDLE || state_n == S_DONE || state_n == S_ERR);
            if (entry_ld) entry <= i_tbl_data[CMD_W-2:0];
            if (retry_clr) retry <= '0;
            else if (retry_inc) retry <= retry + 1'b1;
            if (timer_clr) timer <= '0;
            else if (in_wait) timer <= timer + 1'b1;
            if (accept) begin
                o_done     <= 1'b0;
                o_error    <= 1'b0;
                o_err_code <= 3'd0;
                o_err_addr <= '0;
            end else begin
                if (done_set) o_done <= 1'b1;
                if (err_set) begin
                    o_error    <= 1'b1;
                    o_err_code <= err_code_n;
                    o_err_addr <= err_addr_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_dev_cfg_seq.sv
// Bench for spi_dev_cfg_seq: random tables and SPI responses checked against a command-list model.
module tb_spi_dev_cfg_seq;
    localparam int CMD_W = 24, RD_W = 8, ADDR_W = 7, NUM_ENTRIES = 64;
    localparam int TIMEOUT_CYC = 100, MAX_RETRY = 2;
    localparam logic [CMD_W-1:0] ID_CMD = 24'h008003, FIN_CMD = 24'h00801C;
    localparam logic [RD_W-1:0] ID_VAL = 8'h53, FIN_VAL = 8'h01, FIN_MASK = 8'hFF;

    logic clk = 1'b0, rst = 1'b1, i_cfg_start = 1'b0;
    logic o_spi_wr_cmd, o_spi_rd_cmd, o_busy, o_done, o_error;
    logic [CMD_W-1:0] o_spi_wr_data, i_tbl_data;
    logic [RD_W-1:0] i_spi_rd_data;
    logic i_spi_busy, i_spi_done;
    logic [ADDR_W-1:0] o_tbl_addr, o_err_addr;
    logic [2:0] o_err_code;
    logic [3:0] o_dbg_state;

    spi_dev_cfg_seq #(.CMD_W(CMD_W), .RD_W(RD_W), .ADDR_W(ADDR_W), .NUM_ENTRIES(NUM_ENTRIES),
        .ID_CMD(ID_CMD), .ID_VAL(ID_VAL), .FIN_CMD(FIN_CMD), .FIN_VAL(FIN_VAL), .FIN_MASK(FIN_MASK),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst(rst), .i_cfg_start(i_cfg_start), .o_spi_wr_cmd(o_spi_wr_cmd),
        .o_spi_rd_cmd(o_spi_rd_cmd), .o_spi_wr_data(o_spi_wr_data), .i_spi_rd_data(i_spi_rd_data),
        .i_spi_busy(i_spi_busy), .i_spi_done(i_spi_done), .o_tbl_addr(o_tbl_addr),
        .i_tbl_data(i_tbl_data), .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
        .o_err_code(o_err_code), .o_err_addr(o_err_addr), .o_dbg_state(o_dbg_state));

    // clock / reset
    always #5 clk = ~clk;

    // scenario knobs (written by tasks only)
    logic [CMD_W-1:0] rom [0:(2**ADDR_W)-1];
    logic [RD_W-1:0]  id_resp;
    logic [RD_W-1:0]  fin_arr [$];
    logic [CMD_W-2-RD_W:0] vfy_target;
    int vfy_bad, hang_en, hang_idx;
    int wr_base, obs_base, fin_base, vfy_base;

    // responder state (written by the SPI model only)
    logic [CMD_W:0] obs_q [$];
    logic [CMD_W-1:0] last_wr;
    logic [RD_W-1:0] resp;
    int wr_count = 0, fin_cnt = 0, vfy_used = 0, pulse_cnt = 0, cyc = 0, hang_cyc = 0;
    int lat = 0, tail = 0, t;
    bit pend = 0, hang = 0, leak = 0;

    // expected results
    logic [CMD_W:0] exp_q [$];
    logic [2:0] exp_code;
    logic [ADDR_W-1:0] exp_addr;
    int n_checks = 0, n_pass = 0;

    always @(posedge clk) i_tbl_data <= rom[o_tbl_addr];
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && ((!o_spi_wr_cmd && !o_spi_rd_cmd && o_spi_wr_data !== '0) ||
                     (o_spi_wr_cmd && o_spi_rd_cmd))) leak <= 1'b1;

    // SPI master model: random latency, optional busy tail, scripted read data
    always @(posedge clk) begin
        i_spi_done    <= 1'b0;
        i_spi_rd_data <= RD_W'($urandom);
        if (o_spi_wr_cmd || o_spi_rd_cmd) pulse_cnt <= pulse_cnt + 1;
        if (rst) begin
            pend <= 0; tail <= 0; hang <= 0; i_spi_busy <= 1'b0;
        end else if (o_spi_wr_cmd || o_spi_rd_cmd) begin
            obs_q.push_back({o_spi_rd_cmd, o_spi_wr_data});
            pend <= 1; hang <= 0; i_spi_busy <= 1'b1; lat <= $urandom_range(0, 3);
            if (o_spi_wr_cmd) begin
                last_wr  <= o_spi_wr_data;
                wr_count <= wr_count + 1;
                if (hang_en != 0 && (wr_count - wr_base) == hang_idx) begin
                    hang <= 1; hang_cyc <= cyc;
                end
            end else if (o_spi_wr_data == ID_CMD) begin
                resp <= id_resp;
            end else if (o_spi_wr_data == FIN_CMD) begin
                resp    <= (fin_cnt - fin_base < fin_arr.size()) ? fin_arr[fin_cnt - fin_base] : FIN_VAL;
                fin_cnt <= fin_cnt + 1;
            end else if (o_spi_wr_data[CMD_W-2:RD_W] == vfy_target && (vfy_used - vfy_base) < vfy_bad) begin
                resp     <= ~last_wr[RD_W-1:0];
                vfy_used <= vfy_used + 1;
            end else begin
                resp <= last_wr[RD_W-1:0];
            end
        end else if (pend) begin
            if (lat == 0) begin
                pend <= 0;
                if (!hang) begin i_spi_done <= 1'b1; i_spi_rd_data <= resp; end
                t = $urandom_range(0, 2);
                tail <= t;
                i_spi_busy <= (t != 0);
            end else lat <= lat - 1;
        end else if (tail > 0) begin
            tail <= tail - 1;
            if (tail == 1) i_spi_busy <= 1'b0;
        end
    end

    // behavioural reference: expected command list and outcome of one sequence
    task automatic model_run();
        int bad;
        bit ok;
        logic [CMD_W-1:0] e;
        logic [RD_W-1:0] f;
        exp_q.delete(); exp_code = 3'd0; exp_addr = '0; bad = vfy_bad;
        exp_q.push_back({1'b1, ID_CMD});
        if (id_resp != ID_VAL) begin exp_code = 3'd1; return; end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            e = rom[i];
            if (e == '1) break;
            ok = 0;
`ifdef SPI_CFG_VERIFY_EN
            for (int a = 0; a <= MAX_RETRY; a++) begin
                exp_q.push_back({2'b00, e[CMD_W-2:0]});
                exp_q.push_back({2'b11, e[CMD_W-2:RD_W], {RD_W{1'b0}}});
                if (e[CMD_W-2:RD_W] == vfy_target && bad > 0) bad--;
                else begin ok = 1; break; end
            end
`else
            exp_q.push_back({2'b00, e[CMD_W-2:0]});
            ok = 1;
`endif
            if (!ok) begin exp_code = 3'd3; exp_addr = ADDR_W'(i); return; end
        end
        for (int r = 0; r <= MAX_RETRY; r++) begin
            exp_q.push_back({1'b1, FIN_CMD});
            f = (r < fin_arr.size()) ? fin_arr[r] : FIN_VAL;
            if ((f & FIN_MASK) == (FIN_VAL & FIN_MASK)) return;
        end
        exp_code = 3'd4;
    endtask

    // driver tasks
    task automatic fill_rom(input int marker);
        for (int i = 0; i < 2**ADDR_W; i++) begin
            rom[i] = CMD_W'($urandom);
            rom[i][RD_W +: ADDR_W] = ADDR_W'(i);
        end
        if (marker >= 0) rom[marker] = '1;
    endtask

    task automatic prep(input logic [RD_W-1:0] id);
        id_resp = id; hang_en = 0; hang_idx = 0; vfy_bad = 0; vfy_target = '1;
        wr_base = wr_count; obs_base = obs_q.size(); fin_base = fin_cnt; vfy_base = vfy_used;
    endtask

    task automatic start_and_wait(input int budget, input bit spur, output bit to);
        @(negedge clk) i_cfg_start = 1'b1;
        @(negedge clk) i_cfg_start = 1'b0;
        to = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spur && i == 20) i_cfg_start = 1'b1;
            if (spur && i == 21) i_cfg_start = 1'b0;
            if (o_done || o_error) begin to = 0; break; end
        end
        i_cfg_start = 1'b0;
    endtask

    function automatic int first_diff();
        int n = obs_q.size() - obs_base;
        if (n != exp_q.size()) return (n < exp_q.size()) ? n : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[obs_base + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_busy, o_done, o_error, o_err_code, o_err_addr, o_spi_wr_cmd, o_spi_rd_cmd,
             o_spi_wr_data, o_tbl_addr, o_dbg_state} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b err=%b code=%0d data=%h", o_busy, o_done,
                     o_error, o_err_code, o_spi_wr_data);
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_busy, o_spi_wr_cmd, o_spi_rd_cmd} !== 3'b000)
            $display("FAIL idle_after_reset: busy=%b wr=%b rd=%b want 000", o_busy, o_spi_wr_cmd, o_spi_rd_cmd);
        else n_pass++;
    endtask

    task automatic test_full_table();
        bit to; int d;
        prep(ID_VAL); fill_rom(-1); fin_arr.delete(); model_run();
        start_and_wait(4000, 0, to);
        d = first_diff();
        n_checks++; if (to) $display("FAIL full_timeout: no done/error within budget"); else n_pass++;
        n_checks++; if (d != -1) $display("FAIL full_seq: first diff at %0d, got %0d cmds want %0d", d,
                                         obs_q.size() - obs_base, exp_q.size()); else n_pass++;
        n_checks++; if ((wr_count - wr_base) != NUM_ENTRIES)
            $display("FAIL full_writes: got %0d want %0d", wr_count - wr_base, NUM_ENTRIES); else n_pass++;
        n_checks++; if ({o_done, o_error, o_busy, o_err_code} !== {3'b100, 3'd0})
            $display("FAIL full_status: done=%b err=%b busy=%b code=%0d want 1 0 0 0", o_done, o_error,
                     o_busy, o_err_code); else n_pass++;
    endtask

    task automatic test_id_mismatch();
        bit to; int d;
        prep(8'h52); fill_rom(12); fin_arr.delete(); model_run();
        start_and_wait(500, 0, to);
        d = first_diff();
        n_checks++; if (to || d != -1) $display("FAIL id_seq: timeout=%0b diff=%0d want 0 -1", to, d); else n_pass++;
        n_checks++; if ({o_error, o_done, o_err_code, o_err_addr} !== {2'b10, 3'd1, ADDR_W'(0)})
            $display("FAIL id_err: err=%b done=%b code=%0d addr=%0d want 1 0 1 0", o_error, o_done,
                     o_err_code, o_err_addr); else n_pass++;
        n_checks++; if (wr_count != wr_base) $display("FAIL id_writes: got %0d want 0", wr_count - wr_base); else n_pass++;
        prep(ID_VAL); fill_rom(7); model_run();
        start_and_wait(1000, 0, to);
        d = first_diff();
        n_checks++; if (to || d != -1) $display("FAIL restart_seq: timeout=%0b diff=%0d", to, d); else n_pass++;
        n_checks++; if ({o_done, o_error, o_err_code} !== {2'b10, 3'd0})
            $display("FAIL restart_status: done=%b err=%b code=%0d want 1 0 0", o_done, o_error, o_err_code);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit to; int d, dt;
        prep(ID_VAL); fill_rom(-1); fin_arr.delete(); hang_en = 1; hang_idx = 5;
        exp_q.delete(); exp_q.push_back({1'b1, ID_CMD});
        for (int i = 0; i <= 5; i++) exp_q.push_back({2'b00, rom[i][CMD_W-2:0]});
        start_and_wait(1500, 0, to);
        dt = cyc - hang_cyc;
        d = first_diff();
        n_checks++; if (to || d != -1) $display("FAIL tmo_seq: timeout=%0b diff=%0d", to, d); else n_pass++;
        n_checks++; if ({o_error, o_err_code, o_err_addr} !== {1'b1, 3'd2, ADDR_W'(5)})
            $display("FAIL tmo_err: err=%b code=%0d addr=%0d want 1 2 5", o_error, o_err_code, o_err_addr);
        else n_pass++;
        n_checks++; if (dt < TIMEOUT_CYC || dt > TIMEOUT_CYC + 2)
            $display("FAIL tmo_delay: got %0d cycles want %0d..%0d", dt, TIMEOUT_CYC, TIMEOUT_CYC + 2);
        else n_pass++;
    endtask

    task automatic test_end_marker();
        bit to; int d;
        prep(ID_VAL); fill_rom(10); fin_arr.delete(); model_run();
        start_and_wait(1500, 0, to);
        d = first_diff();
        n_checks++; if (to || d != -1) $display("FAIL marker_seq: timeout=%0b diff=%0d", to, d); else n_pass++;
        n_checks++; if ((wr_count - wr_base) != 10 || o_done !== 1'b1)
            $display("FAIL marker_writes: got %0d done=%b want 10 1", wr_count - wr_base, o_done); else n_pass++;
    endtask

    task automatic test_final_retry();
        bit to; int d;
        prep(ID_VAL); fill_rom($urandom_range(0, 8));
        fin_arr.delete(); fin_arr.push_back(8'h00); fin_arr.push_back(8'h00); fin_arr.push_back(8'h01);
        model_run();
        start_and_wait(1000, 0, to);
        d = first_diff();
        n_checks++; if (to || d != -1 || o_done !== 1'b1)
            $display("FAIL fin_retry_ok: timeout=%0b diff=%0d done=%b", to, d, o_done); else n_pass++;
        prep(ID_VAL); fill_rom($urandom_range(0, 8));
        fin_arr.delete(); repeat (3) fin_arr.push_back(8'h00);
        model_run();
        start_and_wait(1000, 0, to);
        d = first_diff();
        n_checks++; if (to || d != -1) $display("FAIL fin_fail_seq: timeout=%0b diff=%0d", to, d); else n_pass++;
        n_checks++; if ({o_error, o_done, o_err_code, o_err_addr} !== {2'b10, 3'd4, ADDR_W'(0)})
            $display("FAIL fin_fail_err: err=%b done=%b code=%0d addr=%0d want 1 0 4 0", o_error, o_done,
                     o_err_code, o_err_addr); else n_pass++;
    endtask

`ifdef SPI_CFG_VERIFY_EN
    task automatic test_verify();
        bit to; int d;
        prep(ID_VAL); fill_rom($urandom_range(6, 30)); fin_arr.delete();
        vfy_target = rom[3][CMD_W-2:RD_W]; vfy_bad = 2; model_run();
        start_and_wait(3000, 0, to);
        d = first_diff();
        n_checks++; if (to || d != -1 || o_done !== 1'b1)
            $display("FAIL vfy_retry: timeout=%0b diff=%0d done=%b", to, d, o_done); else n_pass++;
        prep(ID_VAL); fill_rom(-1); fin_arr.delete();
        vfy_target = rom[3][CMD_W-2:RD_W]; vfy_bad = 3; model_run();
        start_and_wait(3000, 0, to);
        d = first_diff();
        n_checks++; if ({o_error, o_err_code, o_err_addr} !== {1'b1, exp_code, exp_addr} || d != -1)
            $display("FAIL vfy_err: err=%b code=%0d addr=%0d diff=%0d want 1 %0d %0d -1", o_error,
                     o_err_code, o_err_addr, d, exp_code, exp_addr); else n_pass++;
    endtask
`endif

    task automatic test_back_to_back();
        bit to; int d, m, nf;
        for (int it = 0; it < 4; it++) begin
            prep(($urandom_range(0, 3) == 0) ? RD_W'($urandom) : ID_VAL);
            m = $urandom_range(0, 40);
            fill_rom((m == 40) ? -1 : m);
            fin_arr.delete(); nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) fin_arr.push_back(RD_W'($urandom_range(0, 1)));
            model_run();
            start_and_wait(4000, 1, to);
            d = first_diff();
            n_checks++; if (to || d != -1) $display("FAIL b2b_seq[%0d]: timeout=%0b diff=%0d", it, to, d); else n_pass++;
            n_checks++; if ({o_done, o_error, o_err_code, o_err_addr} !== {exp_code == 0, exp_code != 0, exp_code, exp_addr})
                $display("FAIL b2b_status[%0d]: done=%b err=%b code=%0d addr=%0d want code %0d addr %0d", it,
                         o_done, o_error, o_err_code, o_err_addr, exp_code, exp_addr); else n_pass++;
        end
        n_checks++; if (leak !== 1'b0) $display("FAIL cmd_word_outside_pulse: got %b want 0", leak); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit seen = 0; int base;
        prep(ID_VAL); fill_rom(-1); fin_arr.delete();
        @(negedge clk) i_cfg_start = 1'b1;
        @(negedge clk) i_cfg_start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (wr_count - wr_base == 21) begin seen = 1; break; end
        end
        n_checks++; if (!seen) $display("FAIL rst_mid_reach: write at index 20 not seen"); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        base = pulse_cnt;
        n_checks++;
        if ({o_busy, o_done, o_error, o_err_code, o_err_addr, o_spi_wr_cmd, o_spi_rd_cmd, o_spi_wr_data, o_tbl_addr} !== '0)
            $display("FAIL rst_mid_outputs: busy=%b wr=%b data=%h addr=%0d want all 0", o_busy, o_spi_wr_cmd,
                     o_spi_wr_data, o_tbl_addr); else n_pass++;
        @(negedge clk) rst = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++; if (pulse_cnt != base || o_busy !== 1'b0)
            $display("FAIL rst_mid_quiet: got %0d pulses busy=%b want 0 0", pulse_cnt - base, o_busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_table();
        test_id_mismatch();
        test_timeout();
        test_end_marker();
        test_final_retry();
`ifdef SPI_CFG_VERIFY_EN
        test_verify();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
